// File: rtl/halflife_pkg.sv
// Shared types and constants for the half-life command sequencer.
package halflife_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        HALVE,
        DONE
    } state_e;

    // The halvings counter stops here instead of wrapping back to zero.
    localparam logic [3:0] HALVINGS_MAX = 4'hF;

endpackage

// File: rtl/halflife_tick_gen.sv
// Prescaler plus period counter. A tick fires every presc+1 clocks. After
// max(hl_ticks,1) ticks, period_done pulses for one cycle. clr holds both
// counters at zero, so counting restarts cleanly each time clr is released.
module halflife_tick_gen #(
    parameter int PRESC_W = 8,
    parameter int HL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    input  logic [HL_W-1:0]    hl_ticks,
    output logic               period_done
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [HL_W-1:0]    period_q, period_d;
    logic [HL_W-1:0]    period_last;
    logic               tick;

    // Next-state logic for the prescaler and the period counter.
    // A half-life of zero ticks is treated as one tick.
    always_comb begin
        period_last = (hl_ticks == '0) ? '0 : hl_ticks - HL_W'(1);
        tick        = (presc_q == presc);
        period_done = !clr && tick && (period_q == period_last);

        if (clr || tick) presc_d = '0;
        else             presc_d = presc_q + PRESC_W'(1);

        if (clr || period_done) period_d = '0;
        else if (tick)          period_d = period_q + HL_W'(1);
        else                    period_d = period_q;
    end

    // Counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q  <= '0;
            period_q <= '0;
        end else begin
            presc_q  <= presc_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/halflife_seq.sv
// Half-life command sequencer. It drives the load/down/up/in inputs of a
// downstream up/down/load counter so the count decays by halving (floor)
// once every half-life period, until it reaches zero. The sequencer keeps its
// own shadow copy of the count and never depends on feedback.
// Optional: define HALFLIFE_SEQ_CHECK_EN to compare cnt_in against the shadow
// one cycle after each command. Any mismatch sets the sticky err flag.
module halflife_seq
    import halflife_pkg::*;
#(
    parameter int N       = 4,
    parameter int PRESC_W = 8,
    parameter int HL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N-1:0]       n0,
    input  logic [PRESC_W-1:0] presc,
    input  logic [HL_W-1:0]    hl_ticks,
    input  logic [N-1:0]       cnt_in,
    output logic               up,
    output logic               down,
    output logic               load,
    output logic [N-1:0]       load_val,
    output logic               busy,
    output logic               done,
    output logic [3:0]         halvings,
    output logic               err
);

    state_e             state_q, state_d;
    logic [N-1:0]       load_val_q;
    logic [PRESC_W-1:0] cfg_presc_q;
    logic [HL_W-1:0]    cfg_hl_q;
    logic [N-1:0]       shadow_q;
    logic [N-1:0]       remaining_q;
    logic [3:0]         halvings_q;
    logic               accept_start;
    logic               period_done;

    halflife_tick_gen #(
        .PRESC_W (PRESC_W),
        .HL_W    (HL_W)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .clr         (state_q != RUN),
        .presc       (cfg_presc_q),
        .hl_ticks    (cfg_hl_q),
        .period_done (period_done)
    );

    // Next-state and command decode. abort overrides every transition.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        load         = 1'b0;
        down         = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                busy    = 1'b1;
                state_d = (load_val_q == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (period_done) state_d = HALVE;
            end
            HALVE: begin
                busy = 1'b1;
                down = 1'b1;
                if (remaining_q <= N'(1)) state_d = (shadow_q <= N'(1)) ? DONE : RUN;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            accept_start = 1'b0;
            state_d      = IDLE;
        end
    end

    // State register.
    // NOTE: only control and datapath flops are reset; there are no memories here to worry about.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Configuration latch, shadow count, burst length and halvings counter.
    // The shadow and halvings registers hold their values on abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_val_q  <= '0;
            cfg_presc_q <= '0;
            cfg_hl_q    <= '0;
            shadow_q    <= '0;
            remaining_q <= '0;
            halvings_q  <= '0;
        end else begin
            if (accept_start) begin
                load_val_q  <= n0;
                cfg_presc_q <= presc;
                cfg_hl_q    <= hl_ticks;
            end
            if (!abort) begin
                case (state_q)
                    LOAD: begin
                        shadow_q   <= load_val_q;
                        halvings_q <= '0;
                    end
                    RUN: begin
                        if (period_done) remaining_q <= shadow_q - (shadow_q >> 1);
                    end
                    HALVE: begin
                        if (shadow_q != '0)    shadow_q    <= shadow_q - N'(1);
                        if (remaining_q != '0) remaining_q <= remaining_q - N'(1);
                        if (remaining_q == N'(1) && halvings_q != HALVINGS_MAX)
                            halvings_q <= halvings_q + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign up       = 1'b0;
    assign load_val = load_val_q;
    assign halvings = halvings_q;

`ifdef HALFLIFE_SEQ_CHECK_EN
    logic chk_pend_q;
    logic err_q;

    // One cycle after each command, the downstream counter should match the shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept_start) begin
            chk_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            chk_pend_q <= (load || down) && !abort;
            if (chk_pend_q && (cnt_in != shadow_q)) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_cnt_in;
    assign unused_cnt_in = ^cnt_in;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_halflife_seq.sv
// Directed bench for halflife_seq. A simple model of the downstream counter
// supplies cnt_in. Each sequence is checked burst by burst: a silent gap of
// (presc+1)*max(hl,1) clocks, then ceil(count/2) consecutive down pulses.
module tb_halflife_seq;

    localparam int N       = 4;
    localparam int PRESC_W = 8;
    localparam int HL_W    = 8;

    logic               clk;
    logic               rst;
    logic               start;
    logic               abort;
    logic [N-1:0]       n0;
    logic [PRESC_W-1:0] presc;
    logic [HL_W-1:0]    hl_ticks;
    logic [N-1:0]       cnt_in;
    logic               up;
    logic               down;
    logic               load;
    logic [N-1:0]       load_val;
    logic               busy;
    logic               done;
    logic [3:0]         halvings;
    logic               err;

    int n_checks = 0;
    int n_errors = 0;
    int down_total = 0;
    int excl_viol = 0;
    int up_viol = 0;
    logic [N-1:0] cnt_model;
    logic [N-1:0] cnt_offset;

    halflife_seq #(
        .N       (N),
        .PRESC_W (PRESC_W),
        .HL_W    (HL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .n0       (n0),
        .presc    (presc),
        .hl_ticks (hl_ticks),
        .cnt_in   (cnt_in),
        .up       (up),
        .down     (down),
        .load     (load),
        .load_val (load_val),
        .busy     (busy),
        .done     (done),
        .halvings (halvings),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream counter model driven by the sequencer's commands.
    always @(posedge clk or negedge rst) begin
        if (!rst)      cnt_model <= '0;
        else if (load) cnt_model <= load_val;
        else if (down) cnt_model <= cnt_model - 4'd1;
    end
    assign cnt_in = cnt_model + cnt_offset;

    // Command-bus monitor.
    always @(negedge clk) begin
        if (rst) begin
            if (down) down_total++;
            if (down && load) excl_viol++;
            if (up) up_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_down"}, down, 0);
        check({tag, "_load"}, load, 0);
        check({tag, "_load_val"}, load_val, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_halvings"}, halvings, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_up"}, up, 0);
    endtask

    // Start a sequence and check it through to DONE. Returns the halvings seen.
    task automatic run_seq(input string tag, input int n0v, input int pv, input int hv,
                           output int h_out);
        int s, gap, k, g, d, h;
        @(negedge clk);
        n0 = N'(n0v); presc = PRESC_W'(pv); hl_ticks = HL_W'(hv); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_load"}, load, 1);
        check({tag, "_load_val"}, load_val, n0v);
        check({tag, "_load_busy"}, busy, 1);
        s = n0v; h = 0;
        gap = (pv + 1) * ((hv == 0) ? 1 : hv);
        while (s > 0) begin
            g = 0;
            repeat (gap) begin @(negedge clk); g += int'(down); end
            check({tag, "_gap"}, g, 0);
            k = s - (s >> 1);
            d = 0;
            repeat (k) begin @(negedge clk); d += int'(down); end
            check({tag, "_burst"}, d, k);
            s -= k; h++;
        end
        @(negedge clk);
        check({tag, "_done"}, done, 1);
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_halvings"}, halvings, (h > 15) ? 15 : h);
        h_out = h;
    endtask

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, d0;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        n0 = '0; presc = '0; hl_ticks = '0; cnt_offset = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk); rst = 1'b1;

        // 1: n0=13, presc=0, hl=2 -> bursts 7,3,2,1
        d0 = down_total;
        run_seq("t1", 13, 0, 2, h);
        check("t1_total_downs", down_total - d0, 13);
        check("t1_halvings_hand", halvings, 4);
        check("t1_err", err, 0);

        // 2: n0=0 -> a single load, then DONE, never a down
        d0 = down_total;
        run_seq("t2", 0, 0, 2, h);
        repeat (10) @(negedge clk);
        check("t2_no_down", down_total - d0, 0);
        check("t2_still_done", done, 1);

        // 3: abort on the 3rd down of the first burst
        @(negedge clk);
        n0 = 4'd15; presc = 8'd0; hl_ticks = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;             // LOAD
        repeat (5) @(negedge clk);                // RUN, RUN, HALVE x3
        check("t3_third_down", down, 1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("t3_down_dropped", down, 0);
        check("t3_busy", busy, 0);
        check("t3_done", done, 0);
        check("t3_halvings", halvings, 0);
        d0 = down_total;
        repeat (8) @(negedge clk);
        check("t3_idle_no_down", down_total - d0, 0);
        check("t3_idle_busy", busy, 0);

        // 4: asynchronous reset mid-RUN, then a clean restart
        @(negedge clk);
        n0 = 4'd9; presc = 8'd1; hl_ticks = 8'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;             // LOAD
        @(negedge clk);                           // RUN
        check("t4_in_run", busy, 1);
        #2 rst = 1'b0;
        #1 check_all_zero("t4_async");
        @(negedge clk); rst = 1'b1;
        d0 = down_total;
        run_seq("t4", 4, 0, 1, h);
        check("t4_total_downs", down_total - d0, 4);

        // 5: presc=3, hl=0 -> 4-clock gaps; bursts 4,2,1,1
        run_seq("t5", 8, 3, 0, h);
        check("t5_halvings_hand", halvings, 4);

`ifdef HALFLIFE_SEQ_CHECK_EN
        // 6: corrupt cnt_in after the first down; err must stick until the next start
        @(negedge clk);
        n0 = 4'd13; presc = 8'd0; hl_ticks = 8'd2; start = 1'b1;
        @(negedge clk); start = 1'b0;             // LOAD
        repeat (3) @(negedge clk);                // RUN, RUN, first down
        check("t6_first_down", down, 1);
        cnt_offset = 4'd1;
        repeat (4) @(negedge clk);
        check("t6_err_set", err, 1);
        repeat (30) @(negedge clk);
        check("t6_err_sticky", err, 1);
        check("t6_done", done, 1);
        cnt_offset = 4'd0;
        n0 = 4'd5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("t6_err_cleared", err, 0);
        repeat (3) @(negedge clk);
        check("t6_err_stays_clear", err, 0);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
`endif

        check("excl_load_down", excl_viol, 0);
        check("up_never", up_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/halflife_seq.md
Name: halflife_seq

Overview:
Command sequencer directly upstream of the half-life up/down/load counter. It drives that counter's up/down/load/in inputs to emulate radioactive decay.
- Loads an initial count.
- Every half-life period, emits a burst of down pulses that halves the count (floor).
- Stops when the count reaches zero.
- Keeps its own shadow copy of the counter value, so it never depends on feedback timing.

Parameters:
N, 4, count width (matches downstream counter width)
PRESC_W, 8, prescaler register width
HL_W, 8, half-life period width, in ticks

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  begin sequence (sampled in IDLE or DONE)
abort  in  1  return to IDLE, no further commands
n0  in  N  initial count
presc  in  PRESC_W  tick every presc+1 clocks
hl_ticks  in  HL_W  ticks per half-life; 0 treated as 1
cnt_in  in  N  downstream counter output (used only with the optional feature)
up  out  1  always 0; drives counter up
down  out  1  one-cycle decrement command
load  out  1  one-cycle load command
load_val  out  N  value presented to counter in
busy  out  1  high in LOAD/RUN/HALVE
done  out  1  high while in DONE
halvings  out  4  completed halvings, saturates at 15
err  out  1  sticky mismatch flag (optional feature only; else tied 0)

Behaviour:
- Reset (rst=0, async): state IDLE, shadow=0. All outputs are 0, including load_val, halvings and err.
- Commands are mutually exclusive: at most one of load/down is high per cycle. up is never asserted.
- Control inputs:
  - abort has priority over start and over everything else.
  - abort in any state → IDLE next cycle; down/load drop that cycle edge.
  - shadow and halvings hold their values on abort.
- IDLE: on start, latch n0/presc/hl_ticks; go to LOAD. Config changes after the latch are ignored.
- LOAD (1 cycle):
  - load=1, load_val=latched n0, shadow←n0, halvings←0.
  - Next state: DONE if n0==0, else RUN.
- RUN:
  - Prescaler and period counter clear on entry.
  - Prescaler counts 0..presc; a tick occurs when it equals presc, then it wraps to 0.
  - Period counter increments on each tick.
  - When it reaches max(hl_ticks,1), go to HALVE on the next edge and clear the period counter.
  - With presc=P and hl_ticks=H, HALVE is entered exactly (P+1)·max(H,1) clocks after RUN entry.
- HALVE:
  - On entry, remaining ← shadow − (shadow>>1), i.e. ceil(shadow/2).
  - Each HALVE cycle: down=1, shadow−1, remaining−1.
  - When remaining reaches 0, halvings increments (saturating).
  - Next state: DONE if shadow==0, else RUN.
  - No idle gap between consecutive down pulses.
- DONE: done=1, busy=0; start → LOAD (restart).
- start while busy is ignored.
- load_val holds the last loaded value outside LOAD.
- shadow never underflows.

Optional Feature:
Macro HALFLIFE_SEQ_CHECK_EN.
- Defined: one cycle after each load or down, compare cnt_in against shadow. On mismatch, set err=1; err stays set until reset or the next start.
- Undefined: cnt_in is unused, err is tied 0, and no comparison logic is built.

Decomposition:
- Package halflife_pkg:
  - state enum {IDLE, LOAD, RUN, HALVE, DONE};
  - halvings saturation constant (4'hF).
- Sub-module halflife_tick_gen: the prescaler plus period counter.
  - Inputs: clr, presc, hl_ticks.
  - Output: one-cycle period_done pulse.

Test Plan:
1. presc=0, hl_ticks=2, n0=13, start → load=1 with load_val=13 the cycle after start. Down bursts follow, each preceded by 2 RUN clocks:
   - 7 downs (13→6)
   - 3 downs (6→3)
   - 2 downs (3→1)
   - 1 down (1→0)
   Then done=1, halvings=4, total downs=13.
2. n0=0, start → single load of 0, then done=1 the next cycle, no down ever.
3. n0=15, abort asserted on the 3rd down of the first burst → down=0 from the next cycle, busy=0, state IDLE, halvings=0.
4. rst low mid-RUN → all outputs 0 immediately (asynchronously). After release, start with n0=4 runs cleanly from LOAD.
5. presc=3, hl_ticks=0, n0=8 → first down exactly 4 clocks after RUN entry; burst of 4 downs.
6. Check feature enabled, run as in test 1 but force cnt_in to shadow+1 after the first down → err=1 and stays 1 until the next start.
